rw_cmd_master: RTL and testbench

Synthesizable read/write command master that turns a local request stream into packed commands for a `multisim_client_push` channel and matches returning `multisim_client_pull` responses. Supports up to `MAX_OUTSTANDING` in-flight transactions instead of one blocking transaction at a time. Includes a drain-then-exit sequence toward the exit channel. Sits between emulated/simulated user logic and the multisim client channel instances.

---
 rtl/rw_cmd_pkg.sv | 24 ++
 rtl/rw_cmd_master_if.sv | 72 +++++++
 rtl/rw_tag_fifo.sv | 65 ++++++
 rtl/rw_cmd_master.sv | 219 +++++++++++++++++++++
 tb/tb_rw_cmd_master.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rw_cmd_pkg.sv
// rw_cmd_pkg: shared definitions for the read/write command master.
//   RW_OPCODE_WIDTH  width of the opcode field at the LSBs of a packed command
//   RW_OP_WRITE/READ opcode values placed on the wire
//   rw_state_e       top-level control state (RUN, DRAIN, EXIT, DONE)
//   rw_opcode()      maps the 1-bit request op onto the wide opcode field
package rw_cmd_pkg;

    localparam int unsigned RW_OPCODE_WIDTH = 64;

    localparam logic [RW_OPCODE_WIDTH-1:0] RW_OP_WRITE = 64'd0;
    localparam logic [RW_OPCODE_WIDTH-1:0] RW_OP_READ  = 64'd1;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        EXIT  = 2'd2,
        DONE  = 2'd3
    } rw_state_e;

    function automatic logic [RW_OPCODE_WIDTH-1:0] rw_opcode(input logic op);
        return op ? RW_OP_READ : RW_OP_WRITE;
    endfunction

endpackage

// File: rtl/rw_cmd_master_if.sv
// rw_cmd_master_if: bundles every handshake and status signal of rw_cmd_master.
//   req_*      local request stream (user -> master)
//   cmd_*      packed command toward the push client {wdata, addr, opcode}
//   srv_rsp_*  server response from the pull client
//   rsp_*      matched response back to the user
//   exit_*     exit request / exit channel handshake
//   done, err, outstanding  status
// Modports: master (the command master's view), slave (the surrounding logic).
interface rw_cmd_master_if #(
    parameter int unsigned ADDR_WIDTH      = 64,
    parameter int unsigned DATA_WIDTH      = 64,
    parameter int unsigned MAX_OUTSTANDING = 4
);
    import rw_cmd_pkg::*;

    localparam int unsigned CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned CMD_WIDTH = RW_OPCODE_WIDTH + ADDR_WIDTH + DATA_WIDTH;

    logic                  req_vld;
    logic                  req_rdy;
    logic                  req_op;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;

    logic                  cmd_vld;
    logic                  cmd_rdy;
    logic [CMD_WIDTH-1:0]  cmd_data;

    logic                  srv_rsp_vld;
    logic                  srv_rsp_rdy;
    logic [DATA_WIDTH-1:0] srv_rsp_data;

    logic                  rsp_vld;
    logic                  rsp_rdy;
    logic                  rsp_op;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    logic                  exit_req;
    logic                  exit_vld;
    logic                  exit_ack;

    logic                  done;
    logic                  err;
    logic [CNT_WIDTH-1:0]  outstanding;

    modport master (
        input  req_vld, req_op, req_addr, req_wdata,
        output req_rdy,
        output cmd_vld, cmd_data,
        input  cmd_rdy,
        input  srv_rsp_vld, srv_rsp_data,
        output srv_rsp_rdy,
        output rsp_vld, rsp_op, rsp_rdata,
        input  rsp_rdy,
        input  exit_req, exit_ack,
        output exit_vld, done, err, outstanding
    );

    modport slave (
        output req_vld, req_op, req_addr, req_wdata,
        input  req_rdy,
        input  cmd_vld, cmd_data,
        output cmd_rdy,
        output srv_rsp_vld, srv_rsp_data,
        input  srv_rsp_rdy,
        input  rsp_vld, rsp_op, rsp_rdata,
        output rsp_rdy,
        output exit_req, exit_ack,
        input  exit_vld, done, err, outstanding
    );

endinterface

// File: rtl/rw_tag_fifo.sv
// rw_tag_fifo: small synchronous FIFO holding the op of each in-flight request.
//   clk, rst    clock, synchronous active-high reset (clears storage too)
//   push, wdata write side; ignored when full
//   pop, rdata  read side; rdata shows the head entry, pop ignored when empty
//   full, empty occupancy flags
module rw_tag_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr_q] <= wdata;
                wr_ptr_q      <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (!do_push && do_pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/rw_cmd_master.sv
// rw_cmd_master: turns local read/write requests into packed commands for a push
// client, matches in-order server responses against a tag FIFO, and runs a
// drain-then-exit sequence on request.
//   clk, rst  single clock, synchronous active-high reset
//   bus       rw_cmd_master_if.master: req, cmd, srv_rsp, rsp, exit channels plus
//             done/err/outstanding status
// Optional feature (macro RW_CMD_MASTER_STATS_EN): adds 32-bit wrapping counters
//   wr_count, rd_count  accepted write / read requests
//   stall_count         cycles with cmd_vld && !cmd_rdy
module rw_cmd_master
    import rw_cmd_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 64,
    parameter int unsigned DATA_WIDTH      = 64,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input logic             clk,
    input logic             rst,
    rw_cmd_master_if.master bus
`ifdef RW_CMD_MASTER_STATS_EN
    ,
    output logic [31:0]     wr_count,
    output logic [31:0]     rd_count,
    output logic [31:0]     stall_count
`endif
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned CMD_W = RW_OPCODE_WIDTH + ADDR_WIDTH + DATA_WIDTH;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    rw_state_e             state_q;
    logic                  exit_vld_q;
    logic                  done_q;

    logic                  cmd_vld_q;
    logic [CMD_W-1:0]      cmd_data_q;
    logic                  rsp_vld_q;
    logic                  rsp_op_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic                  err_q;
    logic [CNT_W-1:0]      outstanding_q;

    logic                  cmd_free;
    logic                  req_rdy;
    logic                  req_acc;
    logic                  srv_rsp_rdy;
    logic                  srv_acc;
    logic                  retire;
    logic                  unexpected;
    logic [DATA_WIDTH-1:0] wdata_field;
    logic [CMD_W-1:0]      cmd_next;

    logic [0:0]            tag_op;
    logic                  fifo_full;
    logic                  fifo_empty;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    // Credit check looks only at the registered count, so a retire in the
    // same cycle does not free a slot until the next cycle. The FIFO full
    // flag mirrors outstanding == MAX and only guards the tag store.
    assign cmd_free    = !cmd_vld_q || bus.cmd_rdy;
    assign req_rdy     = (state_q == RUN) && cmd_free && (outstanding_q < MAX_CNT) && !fifo_full;
    assign req_acc     = bus.req_vld && req_rdy;

    assign srv_rsp_rdy = !rsp_vld_q || bus.rsp_rdy;
    assign srv_acc     = bus.srv_rsp_vld && srv_rsp_rdy;
    assign retire      = srv_acc && !fifo_empty;
    assign unexpected  = srv_acc && fifo_empty;

    assign wdata_field = bus.req_op ? '0 : bus.req_wdata;
    assign cmd_next    = {wdata_field, bus.req_addr, rw_opcode(bus.req_op)};

    // ------------------------------------------------------------------
    // Tag FIFO: remembers the op of each issued command, in issue order
    // ------------------------------------------------------------------
    rw_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (1)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (req_acc),
        .wdata (bus.req_op),
        .pop   (retire),
        .rdata (tag_op),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // ------------------------------------------------------------------
    // Command, response and credit datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_vld_q     <= 1'b0;
            cmd_data_q    <= '0;
            rsp_vld_q     <= 1'b0;
            rsp_op_q      <= 1'b0;
            rsp_rdata_q   <= '0;
            err_q         <= 1'b0;
            outstanding_q <= '0;
        end else begin
            // cmd_data holds its value while the push client stalls
            if (req_acc) begin
                cmd_vld_q  <= 1'b1;
                cmd_data_q <= cmd_next;
            end else if (bus.cmd_rdy) begin
                cmd_vld_q <= 1'b0;
            end

            if (retire) begin
                rsp_vld_q   <= 1'b1;
                rsp_op_q    <= tag_op[0];
                rsp_rdata_q <= bus.srv_rsp_data;
            end else if (bus.rsp_rdy) begin
                rsp_vld_q <= 1'b0;
            end

            // A response with nothing in flight is consumed and flagged.
            if (unexpected) begin
                err_q <= 1'b1;
            end

            case ({req_acc, retire})
                2'b10:   outstanding_q <= outstanding_q + 1'b1;
                2'b01:   outstanding_q <= outstanding_q - 1'b1;
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered exit_vld / done
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            exit_vld_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (bus.exit_req) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if ((outstanding_q == '0) && !cmd_vld_q) begin
                        state_q    <= EXIT;
                        exit_vld_q <= 1'b1;
                    end
                end
                EXIT: begin
                    if (bus.exit_ack) begin
                        state_q    <= DONE;
                        exit_vld_q <= 1'b0;
                        done_q     <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= DONE;
                end
                default: begin
                    state_q <= RUN;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Optional statistics counters
    // ------------------------------------------------------------------
`ifdef RW_CMD_MASTER_STATS_EN
    logic [31:0] wr_count_q;
    logic [31:0] rd_count_q;
    logic [31:0] stall_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_count_q    <= '0;
            rd_count_q    <= '0;
            stall_count_q <= '0;
        end else begin
            if (req_acc && !bus.req_op) begin
                wr_count_q <= wr_count_q + 32'd1;
            end
            if (req_acc && bus.req_op) begin
                rd_count_q <= rd_count_q + 32'd1;
            end
            if (cmd_vld_q && !bus.cmd_rdy) begin
                stall_count_q <= stall_count_q + 32'd1;
            end
        end
    end

    assign wr_count    = wr_count_q;
    assign rd_count    = rd_count_q;
    assign stall_count = stall_count_q;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.req_rdy     = req_rdy;
    assign bus.cmd_vld     = cmd_vld_q;
    assign bus.cmd_data    = cmd_data_q;
    assign bus.srv_rsp_rdy = srv_rsp_rdy;
    assign bus.rsp_vld     = rsp_vld_q;
    assign bus.rsp_op      = rsp_op_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.exit_vld    = exit_vld_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;
    assign bus.outstanding = outstanding_q;

endmodule

// File: tb/tb_rw_cmd_master.sv
// tb_rw_cmd_master: directed self-checking bench for rw_cmd_master.
// Inputs change 1 time unit after the rising edge; outputs are checked 2 units
// after it. Counter checks are compiled in when RW_CMD_MASTER_STATS_EN is defined.
module tb_rw_cmd_master;
    import rw_cmd_pkg::*;

    localparam int unsigned AW = 64;
    localparam int unsigned DW = 64;
    localparam int unsigned MO = 4;

    logic        clk = 1'b0;
    logic        rst;
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    rw_cmd_master_if #(
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW),
        .MAX_OUTSTANDING (MO)
    ) bus ();

`ifdef RW_CMD_MASTER_STATS_EN
    logic [31:0] wr_count;
    logic [31:0] rd_count;
    logic [31:0] stall_count;
`endif

    rw_cmd_master #(
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus)
`ifdef RW_CMD_MASTER_STATS_EN
        ,
        .wr_count    (wr_count),
        .rd_count    (rd_count),
        .stall_count (stall_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_vld      = 1'b0;
        bus.req_op       = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        bus.cmd_rdy      = 1'b1;
        bus.srv_rsp_vld  = 1'b0;
        bus.srv_rsp_data = '0;
        bus.rsp_rdy      = 1'b1;
        bus.exit_req     = 1'b0;
        bus.exit_ack     = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        settle();
    endtask

    // One request followed by its server response; checks the user response.
    task automatic txn(input logic op, input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [63:0] srv);
        bus.req_vld   = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        cyc();
        bus.req_vld      = 1'b0;
        bus.srv_rsp_vld  = 1'b1;
        bus.srv_rsp_data = srv;
        cyc();
        bus.srv_rsp_vld = 1'b0;
        settle();
        check_eq("txn_rsp", {bus.rsp_vld, bus.rsp_op, bus.rsp_rdata}, {1'b1, op, srv});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        logic [191:0] exp_cmd;

        // ---------------- reset state ----------------
        do_reset();
        check_eq("rst_req_rdy", bus.req_rdy, 1);
        check_eq("rst_srv_rsp_rdy", bus.srv_rsp_rdy, 1);
        check_eq("rst_status",
                 {bus.cmd_vld, bus.rsp_vld, bus.exit_vld, bus.done, bus.err, bus.outstanding}, 0);

        // ---------------- 1: single write ----------------
        bus.req_vld   = 1'b1;
        bus.req_op    = 1'b0;
        bus.req_addr  = 64'd3;
        bus.req_wdata = 64'hbebecacadeadb00b;
        cyc();
        bus.req_vld = 1'b0;
        settle();
        exp_cmd = {64'hbebecacadeadb00b, 64'd3, 64'd0};
        check_eq("t1_cmd_vld", bus.cmd_vld, 1);
        check_eq("t1_cmd_data", bus.cmd_data, exp_cmd);
        check_eq("t1_outstanding", bus.outstanding, 1);
        bus.srv_rsp_vld  = 1'b1;
        bus.srv_rsp_data = 64'd0;
        cyc();
        bus.srv_rsp_vld = 1'b0;
        settle();
        check_eq("t1_rsp", {bus.rsp_vld, bus.rsp_op, bus.rsp_rdata}, {1'b1, 1'b0, 64'd0});
        check_eq("t1_cmd_vld_clr", bus.cmd_vld, 0);
        check_eq("t1_outstanding_clr", bus.outstanding, 0);
        cyc();
        settle();
        check_eq("t1_rsp_vld_clr", bus.rsp_vld, 0);

        // ---------------- 2: credit limit ----------------
        bus.req_op    = 1'b1;
        bus.req_wdata = 64'hdead_beef;
        for (int i = 0; i < 4; i++) begin
            bus.req_vld  = 1'b1;
            bus.req_addr = 64'(i);
            settle();
            check_eq("t2_req_rdy", bus.req_rdy, 1);
            cyc();
        end
        bus.req_addr = 64'd4;
        settle();
        exp_cmd = {64'd0, 64'd3, 64'd1};
        check_eq("t2_read_cmd", bus.cmd_data, exp_cmd);
        check_eq("t2_full_rdy", bus.req_rdy, 0);
        check_eq("t2_full_cnt", bus.outstanding, 4);
        cyc();
        settle();
        check_eq("t2_still_full", {bus.req_rdy, bus.outstanding}, {1'b0, 3'd4});
        bus.srv_rsp_vld = 1'b1;
        for (int j = 0; j < 4; j++) begin
            bus.srv_rsp_data = 64'h10 + 64'(j);
            cyc();
            if (j == 1) bus.req_vld = 1'b0;
            settle();
            check_eq("t2_rsp", {bus.rsp_vld, bus.rsp_op, bus.rsp_rdata},
                     {1'b1, 1'b1, 64'h10 + 64'(j)});
            if (j == 0) check_eq("t2_credit_back", bus.req_rdy, 1);
            if (j == 1) begin
                exp_cmd = {64'd0, 64'd4, 64'd1};
                check_eq("t2_fifth_cmd", {bus.cmd_vld, bus.cmd_data}, {1'b1, exp_cmd});
            end
        end
        bus.srv_rsp_vld = 1'b0;
        check_eq("t2_after_cnt", bus.outstanding, 1);
        bus.srv_rsp_vld  = 1'b1;
        bus.srv_rsp_data = 64'h14;
        cyc();
        bus.srv_rsp_vld = 1'b0;
        settle();
        check_eq("t2_fifth_rsp", {bus.rsp_vld, bus.rsp_op, bus.rsp_rdata},
                 {1'b1, 1'b1, 64'h14});
        check_eq("t2_final_cnt", bus.outstanding, 0);

        // ---------------- 3: command backpressure ----------------
        do_reset();
        bus.cmd_rdy   = 1'b0;
        bus.req_vld   = 1'b1;
        bus.req_op    = 1'b0;
        bus.req_addr  = 64'd7;
        bus.req_wdata = 64'h1234_5678;
        settle();
        check_eq("t3_first_rdy", bus.req_rdy, 1);
        cyc();
        bus.req_addr  = 64'd8;
        bus.req_wdata = 64'h9999;
        exp_cmd = {64'h1234_5678, 64'd7, 64'd0};
        for (int k = 0; k < 5; k++) begin
            settle();
            check_eq("t3_hold", {bus.cmd_vld, bus.cmd_data, bus.req_rdy}, {1'b1, exp_cmd, 1'b0});
            cyc();
        end
        bus.req_vld = 1'b0;
        settle();
        check_eq("t3_cnt", bus.outstanding, 1);
`ifdef RW_CMD_MASTER_STATS_EN
        check_eq("t3_stall_count", stall_count, 5);
`endif
        bus.cmd_rdy = 1'b1;
        cyc();
        settle();
        check_eq("t3_released", bus.cmd_vld, 0);
`ifdef RW_CMD_MASTER_STATS_EN
        check_eq("t3_stall_hold", stall_count, 5);
`endif
        bus.srv_rsp_vld  = 1'b1;
        bus.srv_rsp_data = 64'h77;
        cyc();
        bus.srv_rsp_vld = 1'b0;
        settle();
        check_eq("t3_rsp", {bus.rsp_vld, bus.rsp_op, bus.rsp_rdata}, {1'b1, 1'b0, 64'h77});

        // ---------------- 4: drain then exit ----------------
        do_reset();
        bus.req_vld  = 1'b1;
        bus.req_op   = 1'b1;
        bus.req_addr = 64'h40;
        cyc();
        bus.req_addr = 64'h41;
        cyc();
        bus.req_vld  = 1'b0;
        bus.exit_req = 1'b1;
        cyc();
        bus.exit_req = 1'b0;
        bus.req_vld  = 1'b1;
        settle();
        check_eq("t4_drain", {bus.req_rdy, bus.exit_vld, bus.outstanding}, {1'b0, 1'b0, 3'd2});
        bus.srv_rsp_vld  = 1'b1;
        bus.srv_rsp_data = 64'ha;
        cyc();
        settle();
        check_eq("t4_exit_low1", bus.exit_vld, 0);
        bus.srv_rsp_data = 64'hb;
        cyc();
        bus.srv_rsp_vld = 1'b0;
        settle();
        check_eq("t4_rsp2", {bus.rsp_vld, bus.rsp_op, bus.rsp_rdata}, {1'b1, 1'b1, 64'hb});
        check_eq("t4_exit_low2", {bus.exit_vld, bus.outstanding}, 0);
        cyc();
        settle();
        check_eq("t4_exit_vld", {bus.exit_vld, bus.done}, {1'b1, 1'b0});
        bus.exit_ack = 1'b1;
        cyc();
        bus.exit_ack = 1'b0;
        settle();
        check_eq("t4_done", {bus.done, bus.exit_vld, bus.req_rdy}, {1'b1, 1'b0, 1'b0});
        cyc();
        cyc();
        settle();
        check_eq("t4_done_sticky", {bus.done, bus.req_rdy, bus.outstanding}, {1'b1, 1'b0, 3'd0});
        bus.req_vld = 1'b0;

        // ---------------- 5: unexpected response ----------------
        do_reset();
        bus.srv_rsp_vld  = 1'b1;
        bus.srv_rsp_data = 64'h99;
        settle();
        check_eq("t5_srv_rdy", bus.srv_rsp_rdy, 1);
        cyc();
        bus.srv_rsp_vld = 1'b0;
        settle();
        check_eq("t5_err", {bus.err, bus.rsp_vld, bus.outstanding}, {1'b1, 1'b0, 3'd0});
        do_reset();
        check_eq("t5_err_clr", bus.err, 0);

        // ---------------- 6: counters and mid-stream reset ----------------
        for (int i = 0; i < 10; i++) txn(1'b0, 64'(i), 64'h100 + 64'(i), 64'h200 + 64'(i));
        for (int i = 0; i < 10; i++) txn(1'b1, 64'(i), 64'h0, 64'h300 + 64'(i));
`ifdef RW_CMD_MASTER_STATS_EN
        check_eq("t6_wr_count", wr_count, 10);
        check_eq("t6_rd_count", rd_count, 10);
`endif
        bus.req_vld = 1'b1;
        bus.req_op  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.req_addr = 64'h50 + 64'(i);
            cyc();
        end
        bus.req_vld = 1'b0;
        bus.cmd_rdy = 1'b0;
        settle();
        check_eq("t6_inflight", {bus.outstanding, bus.cmd_vld}, {3'd3, 1'b1});
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        settle();
        check_eq("t6_rst_status",
                 {bus.cmd_vld, bus.rsp_vld, bus.exit_vld, bus.done, bus.err, bus.outstanding}, 0);
        check_eq("t6_rst_cmd_data", bus.cmd_data, 0);
`ifdef RW_CMD_MASTER_STATS_EN
        check_eq("t6_rst_counters", {wr_count, rd_count, stall_count}, 0);
`endif
        bus.cmd_rdy      = 1'b1;
        // In-flight tags were discarded, so this response has no match.
        bus.srv_rsp_vld  = 1'b1;
        bus.srv_rsp_data = 64'h5;
        cyc();
        bus.srv_rsp_vld = 1'b0;
        settle();
        check_eq("t6_fifo_cleared", {bus.err, bus.rsp_vld}, {1'b1, 1'b0});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
